// File: rtl/spram_arbiter.sv
// Two-port round-robin arbiter and access sequencer for one single-port RAM.
// Latency: gnt one cycle after req is sampled in IDLE; write = 2 cycles, read = 3 cycles (rvalid after RCAP).
// Backpressure: requests are only evaluated in IDLE; a requester holds req until it sees its gnt pulse.
// Ports: clk/rst_n; per client req/we/addr/wdata in, gnt/rvalid/rdata out;
//        RAM side ram_cs/ram_wr/ram_rd/ram_addr out, ram_data inout; busy = FSM not in IDLE.
module spram_arbiter #(
  parameter int AddrWidth = 4,
  parameter int DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic                 we0,
  input  logic [AddrWidth-1:0] addr0,
  input  logic [DataWidth-1:0] wdata0,
  output logic                 gnt0,
  output logic                 rvalid0,
  output logic [DataWidth-1:0] rdata0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [AddrWidth-1:0] addr1,
  input  logic [DataWidth-1:0] wdata1,
  output logic                 gnt1,
  output logic                 rvalid1,
  output logic [DataWidth-1:0] rdata1,
  output logic                 ram_cs,
  output logic                 ram_wr,
  output logic                 ram_rd,
  output logic [AddrWidth-1:0] ram_addr,
  inout  wire  [DataWidth-1:0] ram_data,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RCAP  = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic                 port_q;   // port that owns the current access
  logic                 last_q;   // port granted most recently
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] wdata_q;

  logic                 any_req;
  logic                 win;
  logic                 win_we;
  logic [AddrWidth-1:0] win_addr;
  logic [DataWidth-1:0] win_wdata;

  // Winner selection: on a tie the port that did not win last time gets it.
  always_comb begin
    any_req   = req0 | req1;
    win       = (req0 && req1) ? ~last_q : req1;
    win_we    = win ? we1    : we0;
    win_addr  = win ? addr1  : addr0;
    win_wdata = win ? wdata1 : wdata0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = win_we ? WRITE : READ;
      WRITE:   state_nxt = IDLE;
      READ:    state_nxt = RCAP;
      RCAP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      port_q  <= 1'b0;
      last_q  <= 1'b1;  // port 0 wins the first tie
      addr_q  <= '0;
      wdata_q <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      state   <= state_nxt;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      if (state == IDLE && any_req) begin
        port_q  <= win;
        last_q  <= win;
        addr_q  <= win_addr;
        wdata_q <= win_wdata;
        gnt0    <= ~win;
        gnt1    <= win;
      end
      // Capture happens at the edge ending RCAP; rvalid covers the next cycle,
      // which may overlap the IDLE cycle accepting the next request.
      if (state == RCAP) begin
        if (port_q) begin
          rdata1  <= ram_data;
          rvalid1 <= 1'b1;
        end else begin
          rdata0  <= ram_data;
          rvalid0 <= 1'b1;
        end
      end
    end
  end

  // RAM side is decoded from state so reset drops the strobes immediately.
  always_comb begin
    ram_cs   = (state != IDLE);
    ram_wr   = (state == WRITE);
    ram_rd   = (state == READ) || (state == RCAP);
    ram_addr = addr_q;
    busy     = (state != IDLE);
  end

  assign ram_data = (state == WRITE) ? wdata_q : {DataWidth{1'bz}};

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed self-checking bench for spram_arbiter with a behavioural single-port RAM.
// Inputs are driven 1 time unit after each rising edge and outputs checked at that point.
// The RAM model drives the shared bus only while ram_rd is high.
module tb_spram_arbiter;

  localparam int AW = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          ram_cs, ram_wr, ram_rd, busy;
  logic [AW-1:0] ram_addr;
  wire  [DW-1:0] ram_data;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem [16];

  always #5 clk = ~clk;

  spram_arbiter #(.AddrWidth(AW), .DataWidth(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .ram_cs(ram_cs), .ram_wr(ram_wr), .ram_rd(ram_rd),
    .ram_addr(ram_addr), .ram_data(ram_data), .busy(busy)
  );

  // Behavioural SPRAM
  assign ram_data = ram_rd ? mem[ram_addr] : {DW{1'bz}};
  always @(posedge clk) if (ram_cs && ram_wr) mem[ram_addr] <= ram_data;

  // Strobe exclusivity and chip-select checks every cycle
  always @(negedge clk) begin
    n_assert++;
    assert ((ram_wr && ram_rd) === 1'b0) else begin
      n_fail++;
      $error("FAIL wr_rd_excl: got wr=%0b rd=%0b expected not both", ram_wr, ram_rd);
    end
    n_assert++;
    assert (((ram_wr || ram_rd) && !ram_cs) === 1'b0) else begin
      n_fail++;
      $error("FAIL cs_with_strobe: got cs=%0b wr=%0b rd=%0b", ram_cs, ram_wr, ram_rd);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_port;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rst_n = 1'b0;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    step();
    step();
    // Reset state
    chk("rst_cs", ram_cs, 0);
    chk("rst_wr", ram_wr, 0);
    chk("rst_rd", ram_rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", {gnt0, gnt1}, 0);
    chk("rst_rvalid", {rvalid0, rvalid1}, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_rdata", {rdata0, rdata1}, 0);
    rst_n = 1'b1;
    step();

    // Single write from port 0
    req0 = 1; we0 = 1; addr0 = 4'd3; wdata0 = 32'hDEADBEEF;
    step();
    req0 = 0;
    chk("w_gnt0", gnt0, 1);
    chk("w_gnt1", gnt1, 0);
    chk("w_cs", ram_cs, 1);
    chk("w_wr", ram_wr, 1);
    chk("w_rd", ram_rd, 0);
    chk("w_addr", ram_addr, 3);
    chk("w_data", ram_data, 32'hDEADBEEF);
    chk("w_busy", busy, 1);
    step();
    chk("w_idle_gnt0", gnt0, 0);
    chk("w_idle_cs", ram_cs, 0);
    chk("w_idle_wr", ram_wr, 0);
    chk("w_mem3", mem[3], 32'hDEADBEEF);

    // Port 1 reads it back
    req1 = 1; we1 = 0; addr1 = 4'd3;
    step();
    req1 = 0;
    chk("r_gnt1", gnt1, 1);
    chk("r_cs", ram_cs, 1);
    chk("r_rd", ram_rd, 1);
    chk("r_wr", ram_wr, 0);
    chk("r_addr", ram_addr, 3);
    step();
    chk("r_cap_cs", ram_cs, 1);
    chk("r_cap_rd", ram_rd, 1);
    chk("r_cap_gnt1", gnt1, 0);
    chk("r_cap_rvalid1", rvalid1, 0);
    step();
    chk("r_rvalid1", rvalid1, 1);
    chk("r_rdata1", rdata1, 32'hDEADBEEF);
    chk("r_rvalid0", rvalid0, 0);
    chk("r_idle_cs", ram_cs, 0);
    step();
    chk("r_rvalid1_pulse", rvalid1, 0);

    // Both ports writing continuously: grants alternate starting with port 0
    req0 = 1; we0 = 1; req1 = 1; we1 = 1;
    for (int k = 0; k < 10; k++) begin
      addr0 = AW'(k); wdata0 = 32'hA000_0000 | k;
      addr1 = AW'(k); wdata1 = 32'hB000_0000 | k;
      step();
      exp_port = k[0];
      chk("rr_gnt0", gnt0, !exp_port);
      chk("rr_gnt1", gnt1, exp_port);
      chk("rr_addr", ram_addr, k);
      chk("rr_data", ram_data, exp_port ? (32'hB000_0000 | k) : (32'hA000_0000 | k));
      if (k == 9) begin
        req0 = 0; req1 = 0;
      end
      step();
      chk("rr_idle_busy", busy, 0);
    end
    for (int k = 0; k < 10; k++)
      chk("rr_mem", mem[k], k[0] ? (32'hB000_0000 | k) : (32'hA000_0000 | k));

    // Port 0 alone: four back-to-back reads with req held
    req0 = 1; we0 = 0; addr0 = 4'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("b2b_gnt0", gnt0, 1);
      chk("b2b_addr", ram_addr, i);
      chk("b2b_busy_rd", busy, 1);
      addr0 = AW'(i + 1);
      step();
      chk("b2b_cap_gnt0", gnt0, 0);
      chk("b2b_cap_busy", busy, 1);
      if (i == 3) req0 = 0;
      step();
      chk("b2b_rvalid0", rvalid0, 1);
      chk("b2b_rdata0", rdata0, i[0] ? (32'hB000_0000 | i) : (32'hA000_0000 | i));
      chk("b2b_idle_busy", busy, 0);
      chk("b2b_idle_gnt0", gnt0, 0);
    end
    step();
    chk("b2b_end_busy", busy, 0);
    chk("b2b_end_gnt0", gnt0, 0);
    chk("b2b_end_rvalid0", rvalid0, 0);

    // Reset in the middle of a read
    req1 = 1; we1 = 0; addr1 = 4'd6;
    step();
    req1 = 0;
    chk("ar_pre_rd", ram_rd, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_cs", ram_cs, 0);
    chk("ar_rd", ram_rd, 0);
    chk("ar_gnt", {gnt0, gnt1}, 0);
    chk("ar_rvalid", {rvalid0, rvalid1}, 0);
    chk("ar_busy", busy, 0);
    chk("ar_rdata1", rdata1, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("ar_post_rvalid1", rvalid1, 0);
    chk("ar_post_busy", busy, 0);
    // Tie after reset goes to port 0
    req0 = 1; we0 = 1; addr0 = 4'd7; wdata0 = 32'h1111_2222;
    req1 = 1; we1 = 1; addr1 = 4'd8; wdata1 = 32'h3333_4444;
    step();
    req0 = 0; req1 = 0;
    chk("ar_tie_gnt0", gnt0, 1);
    chk("ar_tie_gnt1", gnt1, 0);
    chk("ar_tie_addr", ram_addr, 7);
    chk("ar_tie_data", ram_data, 32'h1111_2222);
    step();
    chk("ar_tie_idle", busy, 0);
    chk("ar_tie_mem7", mem[7], 32'h1111_2222);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
